// File: rtl/fpga_gen_input_tx.sv
// ---------------------------------------------------------------------------
// fpga_gen_input_tx
//
// Purpose:
//   FPGA-only inbound byte channel into Caliptra firmware. The host pushes
//   bytes through realtime-register strobes into a small circular FIFO. The
//   head byte is presented on generic_input_wires[0] together with a request
//   toggle. Firmware acknowledges by mirroring that toggle on
//   generic_output_wires[1][8]. This is the mirror image of the log FIFO that
//   drains generic_output_wires[0].
//
// Optional feature macro:
//   FPGA_GEN_INPUT_TIMEOUT_EN - when defined, an acknowledge watchdog
//   discards the presented byte after timeout_cycles cycles in WAIT and raises
//   the sticky timeout flag. When undefined, WAIT lasts until acknowledged,
//   timeout is tied low and timeout_cycles is ignored.
//
// Ports:
//   core_clk        in   sole clock
//   srst            in   synchronous active-high reset
//   cptra_rst_b     in   Caliptra core reset (active low, sync to core_clk)
//   wr_en           in   one-cycle push strobe
//   wr_data[7:0]    in   byte to push
//   ack_toggle      in   firmware acknowledge toggle
//   timeout_cycles  in   acknowledge timeout in cycles, 0 disables
//   clr_sticky      in   one-cycle strobe clearing overflow and timeout
//   gen_in[31:0]    out  [7:0] data, [8] request toggle, [31:9] zero
//   fifo_empty      out  FIFO holds no bytes
//   fifo_full       out  FIFO holds DEPTH bytes
//   fifo_count      out  number of bytes held (including the one in flight)
//   busy            out  a byte is presented and not yet acknowledged
//   overflow        out  sticky, a push arrived while full and was dropped
//   timeout         out  sticky, an acknowledge timed out
// ---------------------------------------------------------------------------
module fpga_gen_input_tx #(
    parameter int DEPTH = 16
) (
    input  logic                       core_clk,
    input  logic                       srst,
    input  logic                       cptra_rst_b,
    input  logic                       wr_en,
    input  logic [7:0]                 wr_data,
    input  logic                       ack_toggle,
    input  logic [31:0]                timeout_cycles,
    input  logic                       clr_sticky,
    output logic [31:0]                gen_in,
    output logic                       fifo_empty,
    output logic                       fifo_full,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       busy,
    output logic                       overflow,
    output logic                       timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        StIdle = 1'b0,
        StWait = 1'b1
    } state_t;

    state_t          state_q;
    logic [7:0]      data_q;
    logic            toggle_q;
    logic [AW-1:0]   rdPtr_q, rdPtr_d;
    logic [AW-1:0]   wrPtr_q, wrPtr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q;
    logic [7:0]      mem [DEPTH];

    logic            isEmpty;
    logic            isFull;
    logic            ackMatch;
    logic            popAck;
    logic            popTimeout;
    logic            popFire;
    logic            pushAccept;
    logic            pushDrop;

`ifdef FPGA_GEN_INPUT_TIMEOUT_EN
    logic [31:0]     waitCnt_q;
    logic            timeout_q;
`else
    logic            unusedTimeoutCycles;
    assign unusedTimeoutCycles = ^timeout_cycles;
`endif

    // Pop/push decisions. A pop only happens while Caliptra is out of reset,
    // so the in-flight byte survives a core reset and is re-presented later.
    // A push into a full FIFO is still accepted when the head pops on the
    // same edge, because the popped slot is exactly the one being written.
    always_comb begin
        isEmpty    = (count_q == '0);
        isFull     = (count_q == CW'(DEPTH));
        ackMatch   = (ack_toggle == toggle_q);
        popAck     = cptra_rst_b && (state_q == StWait) && ackMatch;
        popTimeout = 1'b0;
`ifdef FPGA_GEN_INPUT_TIMEOUT_EN
        // Fires on the edge at which the wait counter would reach the limit,
        // i.e. exactly timeout_cycles edges after entering WAIT.
        popTimeout = cptra_rst_b && (state_q == StWait) && !ackMatch &&
                     (timeout_cycles != 32'd0) &&
                     ((waitCnt_q + 32'd1) == timeout_cycles);
`endif
        popFire    = popAck || popTimeout;
        pushAccept = wr_en && (!isFull || popFire);
        pushDrop   = wr_en && isFull && !popFire;

        wrPtr_d = pushAccept ? (wrPtr_q + AW'(1)) : wrPtr_q;
        rdPtr_d = popFire    ? (rdPtr_q + AW'(1)) : rdPtr_q;

        count_d = count_q;
        case ({pushAccept, popFire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array. No reset needed: only slots between the pointers are
    // ever read, and contents must survive a Caliptra core reset anyway.
    always_ff @(posedge core_clk) begin
        if (pushAccept) begin
            mem[wrPtr_q] <= wr_data;
        end
    end

    // Presentation FSM plus FIFO bookkeeping and sticky flags. Data and
    // toggle are only ever written together, so firmware never sees a new
    // toggle paired with stale data. Holding cptra_rst_b low parks the FSM
    // with gen_in at zero, matching the firmware ack register reset value.
    always_ff @(posedge core_clk) begin
        if (srst) begin
            state_q    <= StIdle;
            data_q     <= 8'h00;
            toggle_q   <= 1'b0;
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
`ifdef FPGA_GEN_INPUT_TIMEOUT_EN
            waitCnt_q  <= 32'd0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;

            if (pushDrop) begin
                overflow_q <= 1'b1;
            end else if (clr_sticky) begin
                overflow_q <= 1'b0;
            end
`ifdef FPGA_GEN_INPUT_TIMEOUT_EN
            if (popTimeout) begin
                timeout_q <= 1'b1;
            end else if (clr_sticky) begin
                timeout_q <= 1'b0;
            end
`endif

            if (!cptra_rst_b) begin
                state_q   <= StIdle;
                data_q    <= 8'h00;
                toggle_q  <= 1'b0;
`ifdef FPGA_GEN_INPUT_TIMEOUT_EN
                waitCnt_q <= 32'd0;
`endif
            end else begin
                case (state_q)
                    StIdle: begin
                        if (!isEmpty) begin
                            data_q    <= mem[rdPtr_q];
                            toggle_q  <= ~toggle_q;
                            state_q   <= StWait;
`ifdef FPGA_GEN_INPUT_TIMEOUT_EN
                            waitCnt_q <= 32'd0;
`endif
                        end
                    end
                    StWait: begin
                        if (popAck) begin
                            state_q <= StIdle;
`ifdef FPGA_GEN_INPUT_TIMEOUT_EN
                        end else if (popTimeout) begin
                            // Revert the toggle so req and ack agree again
                            // and the next load is seen as a fresh request.
                            toggle_q <= ack_toggle;
                            state_q  <= StIdle;
                        end else begin
                            waitCnt_q <= waitCnt_q + 32'd1;
`endif
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign gen_in     = {23'd0, toggle_q, data_q};
    assign fifo_empty = isEmpty;
    assign fifo_full  = isFull;
    assign fifo_count = count_q;
    assign busy       = (state_q == StWait);
    assign overflow   = overflow_q;
`ifdef FPGA_GEN_INPUT_TIMEOUT_EN
    assign timeout    = timeout_q;
`else
    assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_gen_input_tx.sv
// ---------------------------------------------------------------------------
// tb_fpga_gen_input_tx
//
// Directed bench for fpga_gen_input_tx. Bytes are recorded in a scoreboard
// queue when pushed and checked against gen_in when the DUT presents them.
// Inputs change 1 time unit after each rising edge, outputs are sampled at
// that same point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_fpga_gen_input_tx;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          core_clk = 1'b0;
    logic          srst;
    logic          cptra_rst_b;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          ack_toggle;
    logic [31:0]   timeout_cycles;
    logic          clr_sticky;
    logic [31:0]   gen_in;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic          busy;
    logic          overflow;
    logic          timeout;

    int            compareCount = 0;
    int            failCount    = 0;
    logic [7:0]    sbQ [$];
    logic          ackTog;

    fpga_gen_input_tx #(.DEPTH(DEPTH)) dut (
        .core_clk       (core_clk),
        .srst           (srst),
        .cptra_rst_b    (cptra_rst_b),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .ack_toggle     (ack_toggle),
        .timeout_cycles (timeout_cycles),
        .clr_sticky     (clr_sticky),
        .gen_in         (gen_in),
        .fifo_empty     (fifo_empty),
        .fifo_full      (fifo_full),
        .fifo_count     (fifo_count),
        .busy           (busy),
        .overflow       (overflow),
        .timeout        (timeout)
    );

    always #5 core_clk = ~core_clk;

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge core_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compareCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Push one byte; record it in the scoreboard only if it should be kept.
    task automatic applyStimulus(input logic [7:0] b, input logic keep);
        wr_en   = 1'b1;
        wr_data = b;
        if (keep) sbQ.push_back(b);
        step();
        wr_en   = 1'b0;
    endtask

    task automatic resetDut();
        srst       = 1'b1;
        ackTog     = 1'b0;
        ack_toggle = 1'b0;
        wr_en      = 1'b0;
        clr_sticky = 1'b0;
        step();
        step();
        srst = 1'b0;
        sbQ.delete();
    endtask

    // Wait (bounded) until a byte with the expected toggle is presented.
    task automatic waitPresent(input string tag, input logic expTog);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (busy === 1'b1 && gen_in[8] === expTog) found = 1;
            else step();
        end
        checkOutput({tag, "_req"}, {30'd0, busy, gen_in[8]}, {30'd0, 1'b1, expTog});
    endtask

    // Firmware model: see the byte, wait lat cycles, return the toggle.
    task automatic serviceOne(input string tag, input logic expTog, input int lat);
        logic [7:0] e;
        waitPresent(tag, expTog);
        e = (sbQ.size() > 0) ? sbQ.pop_front() : 8'hxx;
        checkOutput({tag, "_data"}, gen_in, {23'd0, expTog, e});
        for (int i = 0; i < lat; i++) step();
        checkOutput({tag, "_hold"}, gen_in, {23'd0, expTog, e});
        ackTog     = expTog;
        ack_toggle = ackTog;
        step();
        checkOutput({tag, "_ackbusy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=stuck expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic tog;
        srst           = 1'b1;
        cptra_rst_b    = 1'b1;
        wr_en          = 1'b0;
        wr_data        = 8'h00;
        ack_toggle     = 1'b0;
        ackTog         = 1'b0;
        timeout_cycles = 32'd0;
        clr_sticky     = 1'b0;
        resetDut();

        // Reset state
        checkOutput("rst_gen_in", gen_in, 32'd0);
        checkOutput("rst_flags", {26'd0, fifo_empty, fifo_full, busy, overflow, timeout, 1'b0},
                    {26'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        checkOutput("rst_count", 32'(fifo_count), 32'd0);

        // Single byte: count updates on push edge, byte appears one edge later
        applyStimulus(8'hA5, 1'b1);
        checkOutput("t1_count", 32'(fifo_count), 32'd1);
        checkOutput("t1_busy0", {31'd0, busy}, 32'd0);
        step();
        checkOutput("t1_gen_in", gen_in, {23'd0, 1'b1, sbQ[0]});
        checkOutput("t1_busy1", {31'd0, busy}, 32'd1);
        void'(sbQ.pop_front());
        ackTog = 1'b1; ack_toggle = 1'b1;
        step();
        checkOutput("t1_done", {30'd0, busy, fifo_empty}, {30'd0, 1'b0, 1'b1});

        // Three bytes back to back, firmware acks 3 cycles after each toggle
        resetDut();
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        applyStimulus(8'h33, 1'b1);
        serviceOne("t2_b0", 1'b1, 3);
        serviceOne("t2_b1", 1'b0, 3);
        serviceOne("t2_b2", 1'b1, 3);
        checkOutput("t2_count", 32'(fifo_count), 32'd0);

        // Overflow: DEPTH+1 pushes with no ack, last one dropped
        resetDut();
        for (int i = 0; i <= DEPTH; i++) applyStimulus(8'(8'h40 + i), i < DEPTH);
        checkOutput("t3_full", {29'd0, fifo_full, overflow, 1'b0}, {29'd0, 1'b1, 1'b1, 1'b0});
        checkOutput("t3_count", 32'(fifo_count), 32'(DEPTH));
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        checkOutput("t3_clr", {30'd0, overflow, fifo_full}, {30'd0, 1'b0, 1'b1});
        checkOutput("t3_head", gen_in, {23'd0, 1'b1, sbQ[0]});
        // Push and pop on the same edge while full: accepted, count unchanged
        ackTog = 1'b1; ack_toggle = 1'b1;
        wr_en = 1'b1; wr_data = 8'hEE;
        step();
        wr_en = 1'b0;
        void'(sbQ.pop_front());
        sbQ.push_back(8'hEE);
        checkOutput("t3_pushpop_count", 32'(fifo_count), 32'(DEPTH));
        checkOutput("t3_pushpop_flags", {30'd0, overflow, busy}, 32'd0);
        tog = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            serviceOne("t3_drain", tog, 0);
            tog = ~tog;
        end
        checkOutput("t3_empty", {31'd0, fifo_empty}, 32'd1);

        // Core held in reset: bytes queue up, nothing is presented
        cptra_rst_b = 1'b0;
        ackTog = 1'b0; ack_toggle = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(8'(8'h61 + i), 1'b1);
        checkOutput("t4_gen_in", gen_in, 32'd0);
        checkOutput("t4_count", 32'(fifo_count), 32'd4);
        cptra_rst_b = 1'b1;
        step();
        checkOutput("t4_first", gen_in, {23'd0, 1'b1, sbQ[0]});
        serviceOne("t4_b0", 1'b1, 1);

        // Core reset during WAIT: head retained and re-presented
        waitPresent("t5_pre", 1'b0);
        checkOutput("t5_pre_data", gen_in, {23'd0, 1'b0, sbQ[0]});
        cptra_rst_b = 1'b0;
        ackTog = 1'b0; ack_toggle = 1'b0;
        step();
        checkOutput("t5_gen_in", gen_in, 32'd0);
        checkOutput("t5_state", {31'd0, busy}, 32'd0);
        checkOutput("t5_count", 32'(fifo_count), 32'd3);
        cptra_rst_b = 1'b1;
        step();
        checkOutput("t5_repres", gen_in, {23'd0, 1'b1, sbQ[0]});
        serviceOne("t5_b0", 1'b1, 2);
        serviceOne("t5_b1", 1'b0, 2);
        serviceOne("t5_b2", 1'b1, 2);
        checkOutput("t5_empty", {31'd0, fifo_empty}, 32'd1);

        // Acknowledge timeout with timeout_cycles=10 and no ack
        timeout_cycles = 32'd10;
        applyStimulus(8'h77, 1'b1);
        step();
        checkOutput("t6_enter", gen_in, {23'd0, ~ackTog, 8'h77});
        for (int i = 0; i < 9; i++) step();
        checkOutput("t6_pre", {30'd0, busy, timeout}, {30'd0, 1'b1, 1'b0});
`ifdef FPGA_GEN_INPUT_TIMEOUT_EN
        step();
        void'(sbQ.pop_front());
        checkOutput("t6_fire", {30'd0, busy, timeout}, {30'd0, 1'b0, 1'b1});
        checkOutput("t6_count", 32'(fifo_count), 32'd0);
        checkOutput("t6_toggle", gen_in, {23'd0, ackTog, 8'h77});
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        checkOutput("t6_clr", {31'd0, timeout}, 32'd0);
`else
        for (int i = 0; i < 30; i++) step();
        checkOutput("t6_stuck", {30'd0, busy, timeout}, {30'd0, 1'b1, 1'b0});
        checkOutput("t6_count", 32'(fifo_count), 32'd1);
        checkOutput("t6_data", gen_in, {23'd0, ~ackTog, sbQ.pop_front()});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule

// File: doc/fpga_gen_input_tx.md
# fpga_gen_input_tx

FPGA-only transmitter that moves host-written bytes into Caliptra firmware through `generic_input_wires[0]`, the inbound counterpart of the log FIFO that drains `generic_output_wires[0]`. Host software pushes bytes through realtime-register strobes into an internal FIFO. The block presents one byte at a time using a toggle request/acknowledge handshake, with the acknowledge returned by firmware on `generic_output_wires[1]`. It sits in the FPGA wrapper between the realtime register block and `caliptra_top`.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `core_clk` in 1: sole clock.
- `srst` in 1: synchronous, active-high reset.
- `cptra_rst_b` in 1: Caliptra core reset, active-low, synchronous to `core_clk`.
- `wr_en` in 1: one-cycle push strobe (register `wr_swacc`, delayed one cycle).
- `wr_data` in 8: byte to push.
- `ack_toggle` in 1: `generic_output_wires[1][8]`.
- `timeout_cycles` in 32: acknowledge timeout; 0 disables it.
- `clr_sticky` in 1: one-cycle strobe that clears `overflow` and `timeout`.
- `gen_in` out 32: drives `generic_input_wires[0]`; [7:0] data, [8] req toggle, [31:9] zero.
- `fifo_empty` out 1; `fifo_full` out 1; `fifo_count` out $clog2(DEPTH)+1.
- `busy` out 1: a byte is presented and not yet acknowledged.
- `overflow` out 1: sticky, set when a push arrives while full.
- `timeout` out 1: sticky, set when an acknowledge times out.

## Operation
- FIFO: circular buffer with a read pointer, a write pointer and a count. Pointers wrap modulo DEPTH.
- Push while full: the byte is dropped and `overflow` is set. Push and pop in the same cycle while full: the push is accepted and the count is unchanged.
- FSM states:
  - IDLE: if `cptra_rst_b`=1 and the FIFO is non-empty, load `gen_in[7:0]` from the FIFO head, invert `gen_in[8]`, and go to WAIT.
  - WAIT: `busy`=1. When `ack_toggle`==`gen_in[8]`, pop the FIFO head and go to IDLE. `gen_in[7:0]` holds its value until the next load.
  - TIMEOUT handling (configured builds only): see Configuration.
- `cptra_rst_b`=0, in any state:
  - FSM goes to IDLE.
  - `gen_in` clears to 0, which matches the firmware ack register reset value.
  - The wait counter clears.
  - FIFO contents are retained, so the host may preload bytes before boot.
  - The byte in flight is not popped.
- Sticky flags: set has priority over `clr_sticky` when both occur in the same cycle.

## Timing
- Reset (`srst`): `gen_in`=0, pointers and count=0, `fifo_empty`=1, `fifo_full`=0, `busy`=0, `overflow`=0, `timeout`=0, FSM in IDLE.
- Push at edge k: `fifo_count` updates at k. With IDLE and the FIFO previously empty, the byte and toggle appear on `gen_in` at edge k+1.
- Ack sampled matching at edge m: pop and return to IDLE at m. The next byte, if present, is loaded at m+1. Throughput is one byte per 2 cycles plus the firmware latency.
- `gen_in[7:0]` and `gen_in[8]` always change on the same edge; data is never updated while in WAIT.
- Status outputs are registered and reflect the state after each edge.

## Configuration
- `FPGA_GEN_INPUT_TIMEOUT_EN`:
  - Defined: a 32-bit counter runs in WAIT. When `timeout_cycles`≠0 and the counter reaches `timeout_cycles`, the head byte is popped (discarded), `timeout` is set, `gen_in[8]` is reverted to `ack_toggle` so the pair stays consistent, and the FSM goes to IDLE. The counter clears on entry to WAIT.
  - Undefined: no counter exists, WAIT lasts indefinitely, and `timeout` is tied to 0 while `timeout_cycles` is ignored.

## Test plan
- Reset, then push 0xA5 with `cptra_rst_b`=1 -> one cycle later `gen_in`=0x000001A5 and `busy`=1; drive `ack_toggle`=1 -> next cycle `busy`=0 and `fifo_empty`=1.
- Push 0x11, 0x22, 0x33 back-to-back, with a bench model that acks 3 cycles after each toggle -> bytes are observed in order with toggles 1, 0, 1, and `fifo_count` ends at 0.
- Push DEPTH+1 bytes with no ack -> `fifo_full`=1 and `overflow`=1, the last byte is dropped; pulse `clr_sticky` -> `overflow`=0.
- Hold `cptra_rst_b`=0 and push 4 bytes -> `gen_in`=0 and `fifo_count`=4; release reset -> the first byte is presented with toggle 1.
- Drop `cptra_rst_b` during WAIT -> `gen_in`=0 and IDLE, with the head byte retained; re-presented after release.
- Timeout build with `timeout_cycles`=10 and no ack -> 10 cycles after WAIT entry, `timeout`=1, the count is decremented, and `gen_in[8]`==`ack_toggle`; in a non-timeout build the same stimulus leaves `busy`=1 indefinitely.
